// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: one state per datapath phase, with a
// bounded memory-handshake wait and a sticky ERROR state for faults.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit SUBWORD_EN  = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        MemReady,
  input  logic        TakeBranch,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  PCSource,
  output logic [1:0]  MemSize,
  output logic [3:0]  State,
  output logic        Debug
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ERROR   = 4'd10
  } state_t;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [5:0]    opcode, funct;
  logic          is_load, wait_state, timeout;
  logic [1:0]    size_op;
  logic          unused_bits;

  assign opcode      = Instruction[31:26];
  assign funct       = Instruction[5:0];
  assign unused_bits = ^Instruction[25:6];
  assign is_load     = (opcode == 6'b100011) || (opcode == 6'b100000) || (opcode == 6'b100001);
  assign wait_state  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout     = (MEM_TIMEOUT > 0) && wait_state && !MemReady && (wait_cnt == CNT_LAST);

  always_comb begin
    case (opcode)
      6'b100000, 6'b101000: size_op = 2'b00;
      6'b100001, 6'b101001: size_op = 2'b01;
      default:              size_op = 2'b10;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Counts only while parked in a wait state; any transition (including entry) clears it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt <= '0;
    end else if (wait_state && (next_state == state) && !MemReady) begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    PCSource   = 2'b00;
    MemSize    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        MemSize = 2'b10;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b000000: next_state = (funct == 6'b001000) ? S_JUMP : S_EXEC;
          6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: next_state = S_EXEC;
          6'b100011, 6'b101011: next_state = S_MEMADDR;
          6'b100000, 6'b100001, 6'b101000, 6'b101001:
            next_state = SUBWORD_EN ? S_MEMADDR : S_ERROR;
          6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: next_state = S_BRANCH;
          6'b000010, 6'b000011: next_state = S_JUMP;
          default: next_state = S_ERROR;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        MemSize = size_op;
        if (MemReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        MemSize  = size_op;
        if (MemReady) next_state = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (opcode == 6'b000000) begin
          ALUSrcB = 2'b00;
          ALUOp   = 2'b10;
        end else begin
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = (opcode == 6'b000000) ? 2'b01 : 2'b00;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        PCWrite    = TakeBranch;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        if (opcode == 6'b000000) begin
          PCSource = 2'b11;
        end else begin
          PCSource = 2'b10;
          if (opcode == 6'b000011) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
        end
        next_state = S_FETCH;
      end
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_ERROR;
    endcase
    if (timeout) next_state = S_ERROR;
  end

  assign State = state;
  assign Debug = (state == S_ERROR);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default instance plus a
// SUBWORD_EN=0 / MEM_TIMEOUT=0 instance driven by the same inputs.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instruction;
  logic        MemReady, TakeBranch;

  logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA, Debug;
  logic [1:0] ALUSrcB, ALUOp, RegDst, MemtoReg, PCSource, MemSize;
  logic [3:0] State;

  logic n_PCWrite, n_IRWrite, n_RegWrite, n_MemRead, n_MemWrite, n_IorD, n_ALUSrcA, n_Debug;
  logic [1:0] n_ALUSrcB, n_ALUOp, n_RegDst, n_MemtoReg, n_PCSource, n_MemSize;
  logic [3:0] n_State;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 Clk = ~Clk;

  multicycle_controller dut (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .MemReady(MemReady),
    .TakeBranch(TakeBranch), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .MemSize(MemSize),
    .State(State), .Debug(Debug)
  );

  multicycle_controller #(.MEM_TIMEOUT(0), .SUBWORD_EN(1'b0)) dut_nosub (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .MemReady(MemReady),
    .TakeBranch(TakeBranch), .PCWrite(n_PCWrite), .IRWrite(n_IRWrite),
    .RegWrite(n_RegWrite), .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IorD(n_IorD),
    .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .RegDst(n_RegDst),
    .MemtoReg(n_MemtoReg), .PCSource(n_PCSource), .MemSize(n_MemSize),
    .State(n_State), .Debug(n_Debug)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, State);
    end else begin
      e = exp_q.pop_front();
      chk(tag, State, e);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic mr, input logic tbr);
    Instruction = ins;
    MemReady    = mr;
    TakeBranch  = tbr;
    #1;
  endtask

  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic rst_pulse();
    Rst = 1'b1;
    #1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1;
    Instruction = 32'h0;
    MemReady = 1'b0;
    TakeBranch = 1'b0;
    #1;
    chk("rst_state", State, 4'd0);
    chk("rst_debug", Debug, 1'b0);
    chk("rst_pcwrite", PCWrite, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;

    // lw: 0,1,2,3,4,0
    drive(32'h8C410004, 1'b1, 1'b0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    chk_state("lw_s0");
    chk("lw_f_irwrite", IRWrite, 1'b1);
    chk("lw_f_pcwrite", PCWrite, 1'b1);
    chk("lw_f_memread", MemRead, 1'b1);
    chk("lw_f_memsize", MemSize, 2'b10);
    chk("lw_f_alusrcb", ALUSrcB, 2'b01);
    chk("lw_f_regwrite", RegWrite, 1'b0);
    cyc();
    chk_state("lw_s1");
    chk("lw_d_alusrcb", ALUSrcB, 2'b11);
    chk("lw_d_regwrite", RegWrite, 1'b0);
    cyc();
    chk_state("lw_s2");
    chk("lw_ma_alusrca", ALUSrcA, 1'b1);
    chk("lw_ma_alusrcb", ALUSrcB, 2'b10);
    cyc();
    chk_state("lw_s3");
    chk("lw_rd_memread", MemRead, 1'b1);
    chk("lw_rd_iord", IorD, 1'b1);
    chk("lw_rd_memsize", MemSize, 2'b10);
    chk("lw_rd_regwrite", RegWrite, 1'b0);
    cyc();
    chk_state("lw_s4");
    chk("lw_wb_regwrite", RegWrite, 1'b1);
    chk("lw_wb_memtoreg", MemtoReg, 2'b01);
    chk("lw_wb_regdst", RegDst, 2'b00);
    cyc();
    chk_state("lw_s0_again");
    chk("lw_end_regwrite", RegWrite, 1'b0);

    // add (R-type)
    drive(32'h00221820, 1'b1, 1'b0);
    cyc(); cyc();
    chk("add_exec_state", State, 4'd6);
    chk("add_exec_aluop", ALUOp, 2'b10);
    chk("add_exec_alusrcb", ALUSrcB, 2'b00);
    chk("add_exec_alusrca", ALUSrcA, 1'b1);
    cyc();
    chk("add_wb_state", State, 4'd7);
    chk("add_wb_regdst", RegDst, 2'b01);
    chk("add_wb_regwrite", RegWrite, 1'b1);
    chk("add_wb_memtoreg", MemtoReg, 2'b00);
    cyc();
    chk("add_back_fetch", State, 4'd0);

    // addi (I-type)
    drive(32'h20220005, 1'b1, 1'b0);
    cyc(); cyc();
    chk("addi_exec_aluop", ALUOp, 2'b11);
    chk("addi_exec_alusrcb", ALUSrcB, 2'b10);
    cyc();
    chk("addi_wb_regdst", RegDst, 2'b00);
    chk("addi_wb_regwrite", RegWrite, 1'b1);
    cyc();

    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      drive(32'h10220003, 1'b1, t[0]);
      cyc(); cyc();
      chk("beq_state", State, 4'd8);
      chk("beq_pcwrite", PCWrite, t[0]);
      chk("beq_pcsource", PCSource, 2'b01);
      chk("beq_aluop", ALUOp, 2'b01);
      cyc();
      chk("beq_back_fetch", State, 4'd0);
    end

    // jal
    drive(32'h0C000010, 1'b1, 1'b0);
    cyc(); cyc();
    chk("jal_state", State, 4'd9);
    chk("jal_pcwrite", PCWrite, 1'b1);
    chk("jal_pcsource", PCSource, 2'b10);
    chk("jal_regdst", RegDst, 2'b10);
    chk("jal_memtoreg", MemtoReg, 2'b10);
    chk("jal_regwrite", RegWrite, 1'b1);
    cyc();

    // jr
    drive(32'h03E00008, 1'b1, 1'b0);
    cyc(); cyc();
    chk("jr_state", State, 4'd9);
    chk("jr_pcsource", PCSource, 2'b11);
    chk("jr_regwrite", RegWrite, 1'b0);
    cyc();

    // sh with two stalled MEMWR cycles
    drive(32'hA4410002, 1'b1, 1'b0);
    cyc(); cyc();
    chk("sh_memaddr", State, 4'd2);
    drive(32'hA4410002, 1'b0, 1'b0);
    cyc();
    chk("sh_memwr_state", State, 4'd5);
    chk("sh_memwrite", MemWrite, 1'b1);
    chk("sh_iord", IorD, 1'b1);
    chk("sh_memsize", MemSize, 2'b01);
    cyc();
    chk("sh_stall_state", State, 4'd5);
    drive(32'hA4410002, 1'b1, 1'b0);
    chk("sh_stall_memwrite", MemWrite, 1'b1);
    cyc();
    chk("sh_done", State, 4'd0);

    // sw interrupted by asynchronous reset mid-access
    drive(32'hAC410004, 1'b1, 1'b0);
    cyc(); cyc();
    drive(32'hAC410004, 1'b0, 1'b0);
    cyc();
    chk("sw_memwr_state", State, 4'd5);
    chk("sw_memsize", MemSize, 2'b10);
    #2;
    Rst = 1'b1;
    #1;
    chk("sw_rst_memwrite", MemWrite, 1'b0);
    chk("sw_rst_state", State, 4'd0);
    @(negedge Clk);
    Rst = 1'b0;
    MemReady = 1'b1;
    #1;
    cyc();
    chk("sw_post_rst_decode", State, 4'd1);

    // lb: subword path on the default instance, ERROR on the SUBWORD_EN=0 one
    rst_pulse();
    drive(32'h80410000, 1'b1, 1'b0);
    cyc(); cyc();
    chk("lb_state", State, 4'd2);
    chk("lb_nosub_state", n_State, 4'd10);
    chk("lb_nosub_debug", n_Debug, 1'b1);
    chk("lb_debug", Debug, 1'b0);
    cyc();
    chk("lb_memrd_memsize", MemSize, 2'b00);
    chk("lb_memrd_memread", MemRead, 1'b1);
    cyc(); cyc();
    chk("lb_done", State, 4'd0);
    chk("lb_nosub_sticky", n_State, 4'd10);

    // illegal opcode
    rst_pulse();
    drive(32'hFC000000, 1'b1, 1'b0);
    cyc(); cyc();
    chk("badop_state", State, 4'd10);
    chk("badop_debug", Debug, 1'b1);
    chk("badop_memread", MemRead, 1'b0);
    chk("badop_pcwrite", PCWrite, 1'b0);
    cyc();
    chk("badop_sticky", State, 4'd10);
    #2;
    Rst = 1'b1;
    #1;
    chk("badop_async_rst_state", State, 4'd0);
    chk("badop_async_rst_debug", Debug, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;

    // FETCH timeout: 14 idle cycles stay, the 15th goes to ERROR
    drive(32'h8C410004, 1'b0, 1'b0);
    repeat (14) cyc();
    chk("to_14_state", State, 4'd0);
    cyc();
    chk("to_15_state", State, 4'd10);
    chk("to_15_debug", Debug, 1'b1);
    chk("to_disabled_state", n_State, 4'd0);
    drive(32'h8C410004, 1'b1, 1'b0);
    cyc(); cyc();
    chk("to_sticky_state", State, 4'd10);
    chk("to_sticky_debug", Debug, 1'b1);

    // MemReady arriving on the expiring cycle wins
    rst_pulse();
    drive(32'h8C410004, 1'b0, 1'b0);
    repeat (14) cyc();
    drive(32'h8C410004, 1'b1, 1'b0);
    chk("race_irwrite", IRWrite, 1'b1);
    cyc();
    chk("race_state", State, 4'd1);
    chk("race_debug", Debug, 1'b0);

    // MEMRD timeout with the counter restarted on entry
    cyc();
    drive(32'h8C410004, 1'b0, 1'b0);
    cyc();
    chk("rdto_entry", State, 4'd3);
    repeat (14) cyc();
    chk("rdto_14_state", State, 4'd3);
    cyc();
    chk("rdto_15_state", State, 4'd10);
    chk("rdto_disabled_state", n_State, 4'd3);
    rst_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
